// File: rtl/song_timing_pkg.sv
// Shared timing helpers for the song timebase: phase-increment derivation
// and the start-sequencing state type.
package song_timing_pkg;

    typedef enum logic {
        SEQ_PENDING = 1'b0,
        SEQ_ACTIVE  = 1'b1
    } seq_state_e;

    function automatic longint unsigned round_div(input longint unsigned num,
                                                  input longint unsigned den);
        return (num + den / 2) / den;
    endfunction

    // Per-cycle increment so that carries out of an acc_bits-wide accumulator
    // occur at rate_hz on average.
    function automatic longint unsigned calc_sample_inc(input int clk_hz,
                                                        input int rate_hz,
                                                        input int acc_bits);
        return round_div(64'(rate_hz) << acc_bits, 64'(clk_hz));
    endfunction

    // Increment per BPM unit: sub-ticks per minute per BPM, scaled to the
    // accumulator range and divided by clocks per minute.
    function automatic longint unsigned calc_tick_k(input int clk_hz,
                                                    input int rows_per_beat,
                                                    input int subticks,
                                                    input int acc_bits);
        return round_div(64'(rows_per_beat * subticks) << acc_bits,
                         64'(clk_hz) * 64'd60);
    endfunction

endpackage

// File: rtl/phase_acc_strobe.sv
// Phase accumulator with a registered one-cycle strobe on each carry-out.
module phase_acc_strobe #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] inc,
    output logic             strobe
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // Accumulate while enabled; the carry bit becomes next cycle's strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            strobe <= 1'b0;
        end else if (clear) begin
            acc    <= '0;
            strobe <= 1'b0;
        end else if (en) begin
            acc    <= sum[WIDTH-1:0];
            strobe <= sum[WIDTH];
        end else begin
            strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/song_timebase.sv
// Song timebase: fractional-N sample strobe plus tempo-driven
// sub-tick / row / bar position with an envelope gate window.
//
// state        | meaning
// SEQ_PENDING  | after reset/restart: position 0, bpm tracks input, next run cycle emits row 0
// SEQ_ACTIVE   | row 0 emitted; position advances on each tick carry while run
module song_timebase
    import song_timing_pkg::*;
#(
    parameter int MAIN_CLK_FREQ   = 16000000,
    parameter int SAMPLE_RATE     = 44100,
    parameter int SAMPLE_ACC_BITS = 24,
    parameter int TICK_ACC_BITS   = 32,
    parameter int BPM_BITS        = 8,
    parameter int ROWS_PER_BEAT   = 4,
    parameter int SUBTICKS        = 8,
    parameter int ROWS_PER_BAR    = 16,
    parameter int BAR_BITS        = 8,
    parameter int GATE_SUBTICKS   = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic                            restart,
    input  logic [BPM_BITS-1:0]             bpm,
    output logic                            sample_strobe,
    output logic                            tick_strobe,
    output logic                            row_strobe,
    output logic [$clog2(SUBTICKS)-1:0]     subtick,
    output logic [$clog2(ROWS_PER_BAR)-1:0] row,
    output logic [BAR_BITS-1:0]             bar,
    output logic                            gate
);

    localparam int SUB_W = $clog2(SUBTICKS);
    localparam int ROW_W = $clog2(ROWS_PER_BAR);

    localparam longint unsigned SAMPLE_INC_L =
        calc_sample_inc(MAIN_CLK_FREQ, SAMPLE_RATE, SAMPLE_ACC_BITS);
    localparam longint unsigned TICK_K_L =
        calc_tick_k(MAIN_CLK_FREQ, ROWS_PER_BEAT, SUBTICKS, TICK_ACC_BITS);

    localparam logic [SAMPLE_ACC_BITS-1:0] SAMPLE_INC = SAMPLE_ACC_BITS'(SAMPLE_INC_L);
    localparam logic [TICK_ACC_BITS-1:0]   TICK_K     = TICK_ACC_BITS'(TICK_K_L);
    localparam logic [SUB_W-1:0]           SUB_LAST   = SUB_W'(SUBTICKS - 1);
    localparam logic [ROW_W-1:0]           ROW_LAST   = ROW_W'(ROWS_PER_BAR - 1);

    // An increment of half the range or more could carry on back-to-back cycles.
    if (SAMPLE_INC_L >= (64'd1 << (SAMPLE_ACC_BITS - 1))) begin : g_sample_inc_check
        $error("song_timebase: sample increment too large for accumulator width");
    end

    typedef struct packed {
        logic [BAR_BITS-1:0] bar;
        logic [ROW_W-1:0]    row;
        logic [SUB_W-1:0]    subtick;
    } pos_t;

    seq_state_e                seq_state;
    pos_t                      pos_q;
    logic [BPM_BITS-1:0]       bpm_q;
    logic [TICK_ACC_BITS-1:0]  tick_inc;
    logic                      run_q;
    logic                      adv;
    logic                      tick_clear;

    phase_acc_strobe #(
        .WIDTH (SAMPLE_ACC_BITS)
    ) u_sample_acc (
        .clk    (clk),
        .rst    (rst),
        .en     (1'b1),
        .clear  (1'b0),
        .inc    (SAMPLE_INC),
        .strobe (sample_strobe)
    );

    // Tick phase restarts from zero whenever the song stops or restarts, so
    // a resume always waits a full sub-tick before the next advance.
    assign tick_clear = restart | ~run;

    phase_acc_strobe #(
        .WIDTH (TICK_ACC_BITS)
    ) u_tick_acc (
        .clk    (clk),
        .rst    (rst),
        .en     (run),
        .clear  (tick_clear),
        .inc    (tick_inc),
        .strobe (adv)
    );

    // Tempo increment follows the latched bpm one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_inc <= '0;
        end else begin
            tick_inc <= TICK_ACC_BITS'(bpm_q) * TICK_K;
        end
    end

    // Start sequencing, position counters and tick/row strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_state   <= SEQ_PENDING;
            pos_q       <= '0;
            bpm_q       <= '0;
            run_q       <= 1'b0;
            tick_strobe <= 1'b0;
            row_strobe  <= 1'b0;
        end else begin
            run_q       <= run;
            tick_strobe <= 1'b0;
            row_strobe  <= 1'b0;
            if (restart) begin
                seq_state <= SEQ_PENDING;
                pos_q     <= '0;
                bpm_q     <= bpm;
            end else if (seq_state == SEQ_PENDING) begin
                // Sitting on a row boundary: keep tempo current until row 0 plays.
                bpm_q <= bpm;
                if (run) begin
                    seq_state   <= SEQ_ACTIVE;
                    pos_q       <= '0;
                    tick_strobe <= 1'b1;
                    row_strobe  <= 1'b1;
                end
            end else if (run && adv) begin
                tick_strobe <= 1'b1;
                if (pos_q.subtick == SUB_LAST) begin
                    pos_q.subtick <= '0;
                    row_strobe    <= 1'b1;
                    bpm_q         <= bpm;
                    if (pos_q.row == ROW_LAST) begin
                        pos_q.row <= '0;
                        pos_q.bar <= pos_q.bar + BAR_BITS'(1);
                    end else begin
                        pos_q.row <= pos_q.row + ROW_W'(1);
                    end
                end else begin
                    pos_q.subtick <= pos_q.subtick + SUB_W'(1);
                end
            end
        end
    end

    assign subtick = pos_q.subtick;
    assign row     = pos_q.row;
    assign bar     = pos_q.bar;
    assign gate    = run_q && (32'(pos_q.subtick) < 32'(GATE_SUBTICKS));

endmodule

// File: tb/tb_song_timebase.sv
// Directed bench for song_timebase, scaled down (1 kHz clock, narrow
// accumulators, 4 rows x 4 bars) so full bar wraps fit in a short run.
`timescale 1ns/1ps
module tb_song_timebase;

    localparam int MAIN_CLK_FREQ   = 1000;
    localparam int SAMPLE_RATE     = 100;
    localparam int SAMPLE_ACC_BITS = 12;
    localparam int TICK_ACC_BITS   = 16;
    localparam int BPM_BITS        = 8;
    localparam int ROWS_PER_BEAT   = 4;
    localparam int SUBTICKS        = 8;
    localparam int ROWS_PER_BAR    = 4;
    localparam int BAR_BITS        = 2;
    localparam int GATE_SUBTICKS   = 6;
    // Hand-derived: sample inc 410 of 4096 -> spacing 9..10; TICK_K 35,
    // so tick inc = 35*bpm of 65536 (bpm 120 -> 15..16, 240/255 -> 7..8).

    logic                clk = 1'b0;
    logic                rst;
    logic                run;
    logic                restart;
    logic [BPM_BITS-1:0] bpm;
    logic                sample_strobe;
    logic                tick_strobe;
    logic                row_strobe;
    logic [2:0]          subtick;
    logic [1:0]          row;
    logic [BAR_BITS-1:0] bar;
    logic                gate;

    int checks = 0;
    int errors = 0;

    song_timebase #(
        .MAIN_CLK_FREQ   (MAIN_CLK_FREQ),
        .SAMPLE_RATE     (SAMPLE_RATE),
        .SAMPLE_ACC_BITS (SAMPLE_ACC_BITS),
        .TICK_ACC_BITS   (TICK_ACC_BITS),
        .BPM_BITS        (BPM_BITS),
        .ROWS_PER_BEAT   (ROWS_PER_BEAT),
        .SUBTICKS        (SUBTICKS),
        .ROWS_PER_BAR    (ROWS_PER_BAR),
        .BAR_BITS        (BAR_BITS),
        .GATE_SUBTICKS   (GATE_SUBTICKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .restart       (restart),
        .bpm           (bpm),
        .sample_strobe (sample_strobe),
        .tick_strobe   (tick_strobe),
        .row_strobe    (row_strobe),
        .subtick       (subtick),
        .row           (row),
        .bar           (bar),
        .gate          (gate)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bpm;
        int n_ticks;
        int exp_sub;
        int exp_row;
        int exp_bar;
        int exp_gate;
        int sp_lo;
        int sp_hi;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string name, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 5000) begin
            step();
            n++;
            hit = (tick_strobe === 1'b1);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: got no tick_strobe, expected one within %0d cycles", name, n);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        int n, cnt_tick, cnt_row, cnt_gate, cnt_samp, last_samp, sp_min, sp_max, moved;

        //            bpm  ticks sub row bar gate  sp_lo sp_hi
        vecs[0] = '{  120,    7,  7,  0,  0,  0,    15,   16};
        vecs[1] = '{  120,    9,  1,  1,  0,  1,    15,   16};
        vecs[2] = '{  240,    8,  0,  1,  0,  1,     7,    8};
        vecs[3] = '{  255,   31,  7,  3,  0,  0,     7,    8};
        vecs[4] = '{  255,   32,  0,  0,  1,  1,     7,    8};
        vecs[5] = '{  255,  127,  7,  3,  3,  0,     7,    8};
        vecs[6] = '{  255,  128,  0,  0,  0,  1,     7,    8};
        vecs[7] = '{   60,    3,  3,  0,  0,  1,    31,   32};
        vecs[8] = '{    1,    2,  2,  0,  0,  1,  1872, 1873};

        rst = 1'b1; run = 1'b0; restart = 1'b0; bpm = 8'd120;

        // Reset held: every output low.
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_outputs",
                  int'({sample_strobe, tick_strobe, row_strobe, gate, subtick, row, bar}), 0);
        end
        rst = 1'b0;

        // Idle after reset: no ticks or gate, sample strobe free-running.
        cnt_tick = 0; cnt_row = 0; cnt_gate = 0; cnt_samp = 0;
        last_samp = -1; sp_min = 1000000; sp_max = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (tick_strobe) cnt_tick++;
            if (row_strobe) cnt_row++;
            if (gate) cnt_gate++;
            if (sample_strobe) begin
                cnt_samp++;
                if (last_samp >= 0) begin
                    if (i - last_samp < sp_min) sp_min = i - last_samp;
                    if (i - last_samp > sp_max) sp_max = i - last_samp;
                end
                last_samp = i;
            end
        end
        check("idle_tick_count", cnt_tick, 0);
        check("idle_row_count", cnt_row, 0);
        check("idle_gate_count", cnt_gate, 0);
        check_range("sample_count", cnt_samp, 1000, 1001);
        check_range("sample_spacing_min", sp_min, 9, 10);
        check_range("sample_spacing_max", sp_max, 9, 10);

        // Table: restart at a tempo, count ticks, check position and spacing.
        run = 1'b1;
        for (int v = 0; v < 9; v++) begin
            bpm = BPM_BITS'(vecs[v].bpm);
            pulse_restart();
            check($sformatf("v%0d_restart_quiet", v), int'(tick_strobe), 0);
            step();
            check($sformatf("v%0d_start_strobes", v), int'({tick_strobe, row_strobe}), 3);
            check($sformatf("v%0d_start_pos", v), int'({subtick, row, bar}), 0);
            sp_min = 1000000; sp_max = 0;
            for (int t = 1; t <= vecs[v].n_ticks; t++) begin
                wait_tick($sformatf("v%0d_tick%0d", v, t), n);
                if (t >= 2) begin
                    if (n < sp_min) sp_min = n;
                    if (n > sp_max) sp_max = n;
                end
            end
            check($sformatf("v%0d_subtick", v), int'(subtick), vecs[v].exp_sub);
            check($sformatf("v%0d_row", v), int'(row), vecs[v].exp_row);
            check($sformatf("v%0d_bar", v), int'(bar), vecs[v].exp_bar);
            check($sformatf("v%0d_gate", v), int'(gate), vecs[v].exp_gate);
            check($sformatf("v%0d_row_strobe", v), int'(row_strobe), int'(vecs[v].exp_sub == 0));
            if (vecs[v].n_ticks >= 2) begin
                check_range($sformatf("v%0d_spacing_min", v), sp_min, vecs[v].sp_lo, vecs[v].sp_hi);
                check_range($sformatf("v%0d_spacing_max", v), sp_max, vecs[v].sp_lo, vecs[v].sp_hi);
            end
        end

        // Tempo change mid-row only takes effect at the next row boundary.
        bpm = 8'd120;
        pulse_restart();
        step();
        for (int t = 0; t < 3; t++) wait_tick("tempo_lead", n);
        check("tempo_at_sub3", int'(subtick), 3);
        bpm = 8'd240;
        sp_min = 1000000; sp_max = 0;
        for (int t = 0; t < 5; t++) begin
            wait_tick("tempo_old_row", n);
            if (n < sp_min) sp_min = n;
            if (n > sp_max) sp_max = n;
        end
        check_range("tempo_old_min", sp_min, 15, 16);
        check_range("tempo_old_max", sp_max, 15, 16);
        check("tempo_boundary_row_strobe", int'(row_strobe), 1);
        check("tempo_boundary_subtick", int'(subtick), 0);
        wait_tick("tempo_first_fast", n);
        check_range("tempo_first_fast", n, 7, 9);
        sp_min = 1000000; sp_max = 0;
        for (int t = 0; t < 3; t++) begin
            wait_tick("tempo_fast", n);
            if (n < sp_min) sp_min = n;
            if (n > sp_max) sp_max = n;
        end
        check_range("tempo_fast_min", sp_min, 7, 8);
        check_range("tempo_fast_max", sp_max, 7, 8);

        // Restart timing at bpm 240 from a cleared accumulator: the carry lands
        // 8 adds after the start cycle, so the first tick follows 8 cycles later.
        bpm = 8'd240;
        pulse_restart();
        for (int i = 0; i < 5; i++) step();
        pulse_restart();
        check("rs_quiet", int'({tick_strobe, row_strobe, subtick, row, bar}), 0);
        step();
        check("rs_start", int'({tick_strobe, row_strobe}), 3);
        wait_tick("rs_first_tick", n);
        check("rs_first_tick_delay", n, 8);
        check("rs_first_tick_sub", int'(subtick), 1);

        // Same again, but restart lands on the cycle that would have ticked.
        pulse_restart();
        step();
        check("rc_start", int'({tick_strobe, row_strobe}), 3);
        cnt_tick = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (tick_strobe) cnt_tick++;
        end
        check("rc_no_early_tick", cnt_tick, 0);
        pulse_restart();
        check("rc_restart_wins_strobe", int'({tick_strobe, row_strobe}), 0);
        check("rc_restart_wins_pos", int'({subtick, row, bar}), 0);
        step();
        check("rc_row0_next", int'({tick_strobe, row_strobe}), 3);
        check("rc_row0_pos", int'({subtick, row, bar}), 0);

        // Run toggle: freeze, gate low, resume without an immediate strobe.
        for (int t = 0; t < 10; t++) wait_tick("rt_lead", n);
        check("rt_pos_before", int'({bar, row, subtick}), (0 << 5) | (1 << 3) | 2);
        run = 1'b0;
        cnt_tick = 0; cnt_row = 0; cnt_gate = 0; moved = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tick_strobe) cnt_tick++;
            if (row_strobe) cnt_row++;
            if (gate) cnt_gate++;
            if ({bar, row, subtick} != 7'b0001010) moved++;
        end
        check("rt_stopped_ticks", cnt_tick, 0);
        check("rt_stopped_rows", cnt_row, 0);
        check("rt_stopped_gate", cnt_gate, 0);
        check("rt_stopped_moved", moved, 0);
        run = 1'b1;
        step();
        check("rt_resume_no_strobe", int'(tick_strobe), 0);
        check("rt_resume_gate", int'(gate), 1);
        wait_tick("rt_resume_tick", n);
        check("rt_resume_delay", n, 8);
        check("rt_resume_pos", int'({bar, row, subtick}), (0 << 5) | (1 << 3) | 3);

        // Asynchronous reset mid-cycle while a tick strobe is high.
        wait_tick("ar_tick", n);
        check("ar_tick_high", int'(tick_strobe), 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_async_clear",
              int'({sample_strobe, tick_strobe, row_strobe, gate, subtick, row, bar}), 0);
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_timebase.md
Name: song_timebase

Overview:
- Parametrised timing generator for the song player. It replaces fixed integer clock dividers with phase-accumulator (fractional-N) strobes, which gives jitter-free average rates.
- Produces a free-running sample strobe and a runtime-tempo tick/sub-tick/row/bar position, plus an envelope gate window.
- Sits between the top-level clock and song_player/voices.
- All outputs are single-cycle enables in the clk domain, not derived clocks.

Parameters:
- MAIN_CLK_FREQ, 16000000, clk frequency in Hz.
- SAMPLE_RATE, 44100, target sample strobe rate in Hz.
- SAMPLE_ACC_BITS, 24, sample phase accumulator width.
- TICK_ACC_BITS, 32, tick phase accumulator width.
- BPM_BITS, 8, tempo input width (quarter notes per minute).
- ROWS_PER_BEAT, 4, rows per quarter note (16th-note rows).
- SUBTICKS, 8, sub-ticks per row (power of two).
- ROWS_PER_BAR, 16, rows per bar.
- BAR_BITS, 8, bar counter width.
- GATE_SUBTICKS, 6, sub-ticks per row during which gate is high.

Ports:
- clk  in  1  main clock.
- rst  in  1  asynchronous active-high reset.
- run  in  1  high = position advances; low = tick accumulator held at 0, position frozen.
- restart  in  1  single-cycle pulse: position to row 0 of bar 0.
- bpm  in  BPM_BITS  tempo; sampled at row boundaries.
- sample_strobe  out  1  one-cycle pulse at SAMPLE_RATE average.
- tick_strobe  out  1  one-cycle pulse per sub-tick.
- row_strobe  out  1  one-cycle pulse at start of each row (coincides with tick_strobe when subtick==0).
- subtick  out  $clog2(SUBTICKS)  current sub-tick index.
- row  out  $clog2(ROWS_PER_BAR)  current row in bar.
- bar  out  BAR_BITS  current bar, wraps modulo 2^BAR_BITS.
- gate  out  1  high while run and subtick < GATE_SUBTICKS.

Behaviour:
- Reset (async, rst=1): all accumulators 0, subtick/row/bar 0, all strobes 0, gate 0, latched bpm_q = bpm input value at reset release, pending_start=1.
- Sample path:
  - SAMPLE_INC = round(SAMPLE_RATE*2^SAMPLE_ACC_BITS/MAIN_CLK_FREQ); defaults give 46242.
  - Each cycle: acc += SAMPLE_INC, unsigned, wrap.
  - sample_strobe is registered: high the cycle after carry-out.
  - Independent of run/restart; never two consecutive high cycles (elaboration assert SAMPLE_INC < 2^(SAMPLE_ACC_BITS-1)).
- Tick path:
  - TICK_K = round(ROWS_PER_BEAT*SUBTICKS*2^TICK_ACC_BITS/(60*MAIN_CLK_FREQ)); defaults give 143.
  - tick_inc register = bpm_q*TICK_K, width TICK_ACC_BITS. Recomputed one cycle after bpm_q loads (one multiply, registered).
  - While run=1: tick_acc += tick_inc; carry-out asserts internal adv.
  - bpm_q=0 means tick_inc=0, so no ticks and position holds.
- Advance, registered so outputs update the cycle after adv:
  - subtick+1 wraps at SUBTICKS.
  - On wrap: row+1. Row wraps at ROWS_PER_BAR, and on that wrap bar+1.
  - tick_strobe=1. row_strobe=1 if new subtick==0.
  - bpm_q <= bpm when new subtick==0, so tempo changes take effect only on row boundaries.
- Start: when pending_start and run=1, the next cycle emits tick_strobe=row_strobe=1 with position 0/0/0. This ensures row 0 is played, not skipped. pending_start then clears.
- restart=1:
  - Same cycle: tick_acc<=0, subtick/row/bar<=0, bpm_q<=bpm, pending_start<=1.
  - Overrides a coincident adv (restart wins; no strobe from that adv).
- run falling: tick_acc<=0, position frozen, gate=0, no tick/row strobes. run rising resumes from the frozen position with no immediate strobe (unless pending_start).
- gate is combinational from registered run and subtick; no glitch requirements beyond registered sources.
- Reset mid-operation: immediate async clear; strobes drop in the same cycle.

Decomposition:
- Package song_timing_pkg: SAMPLE_INC/TICK_K derivation functions, position struct (subtick, row, bar).
- One sub-module, phase_acc_strobe: parameter WIDTH; inputs clk, rst, en, clear, inc; output strobe. Instantiated twice (sample, tick).
- Position counters and start logic stay in song_timebase.

Test Plan:
- Reset: rst high 5 cycles, run=0 -> all outputs 0; after release with no run, tick_strobe never asserts over 10000 cycles.
- Sample rate: run 1,000,000 cycles -> sample_strobe count 2756 or 2757; strobe spacing always 362 or 363 cycles.
- Tempo: bpm=120, run=1 -> first tick_strobe+row_strobe at row 0 one cycle after start; subsequent tick spacing 250289 or 250290 cycles; gate high for subticks 0–5, low for 6–7.
- Bar wrap (SUBTICKS=2, ROWS_PER_BAR=4, MAIN_CLK_FREQ=960000, bpm=255 override): after 8 ticks row returns to 0 and bar increments to 1; BAR_BITS=2 wraps bar 3 -> 0.
- Tempo change mid-row: bpm 120->240 at subtick 3 -> spacing unchanged until next row_strobe, then halves (±1 cycle).
- Restart coincident with adv, and run toggle: restart wins (no strobe that cycle, position 0, row_strobe next cycle); run low 1000 cycles freezes position with gate=0; run high resumes with no immediate strobe.
